// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter: shares the register bank write port between ALU and MEM.
// Optional WB_R0_PROTECT_EN drops architectural writes to register 0.
module regfile_wb_arbiter #(
    parameter int DATA_W       = 16,
    parameter int NREG         = 8,
    parameter int STARVE_LIMIT = 3,
    localparam int AW          = $clog2(NREG)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              alu_valid,
    input  logic [AW-1:0]     alu_rd,
    input  logic [DATA_W-1:0] alu_data,
    output logic              alu_ready,
    input  logic              mem_valid,
    input  logic [AW-1:0]     mem_rd,
    input  logic [DATA_W-1:0] mem_data,
    output logic              mem_ready,
    input  logic              issue_valid,
    input  logic [AW-1:0]     issue_rd,
    output logic              RegWrite,
    output logic [AW-1:0]     wr_reg,
    output logic [DATA_W-1:0] wr_data,
    output logic [NREG-1:0]   busy
);

    typedef enum logic {
        PRIO_MEM = 1'b0,
        PRIO_ALU = 1'b1
    } prio_e;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    prio_e             state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [AW-1:0]     reg_q, reg_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [NREG-1:0]   busy_q, busy_d;

    logic              alu_gnt, mem_gnt, gnt, drop;
    logic [AW-1:0]     gnt_rd;
    logic [DATA_W-1:0] gnt_data;

    always_comb begin
        alu_gnt = 1'b0;
        mem_gnt = 1'b0;
        if (!reset) begin
            case (state_q)
                PRIO_MEM: begin
                    mem_gnt = mem_valid;
                    alu_gnt = alu_valid && !mem_valid;
                end
                PRIO_ALU: begin
                    alu_gnt = alu_valid;
                    mem_gnt = mem_valid && !alu_valid;
                end
                default: begin
                    alu_gnt = 1'b0;
                    mem_gnt = 1'b0;
                end
            endcase
        end
    end

    assign alu_ready = alu_gnt;
    assign mem_ready = mem_gnt;
    assign gnt       = alu_gnt || mem_gnt;
    assign gnt_rd    = alu_gnt ? alu_rd : mem_rd;
    assign gnt_data  = alu_gnt ? alu_data : mem_data;

`ifdef WB_R0_PROTECT_EN
    // The handshake still completes; only the bank write is suppressed.
    assign drop = (gnt_rd == '0);
`else
    assign drop = 1'b0;
`endif

    always_comb begin
        cnt_d = cnt_q;
        if (alu_gnt) begin
            cnt_d = '0;
        end else if (alu_valid && cnt_q != 4'hF) begin
            cnt_d = cnt_q + 4'd1;
        end

        state_d = state_q;
        case (state_q)
            PRIO_MEM: if (cnt_d >= LIMIT) state_d = PRIO_ALU;
            PRIO_ALU: if (alu_gnt) state_d = PRIO_MEM;
            default:  state_d = PRIO_MEM;
        endcase
    end

    always_comb begin
        we_d   = gnt && !drop;
        reg_d  = we_d ? gnt_rd : reg_q;
        data_d = we_d ? gnt_data : data_q;

        // A same-cycle issue overrides the clear: a newer producer is pending.
        busy_d = busy_q;
        if (gnt) busy_d[gnt_rd] = 1'b0;
        if (issue_valid) busy_d[issue_rd] = 1'b1;
`ifdef WB_R0_PROTECT_EN
        busy_d[0] = 1'b0;
`endif
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= PRIO_MEM;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            reg_q   <= '0;
            data_q  <= '0;
            busy_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            reg_q   <= reg_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
        end
    end

    assign RegWrite = we_q;
    assign wr_reg   = reg_q;
    assign wr_data  = data_q;
    assign busy     = busy_q;

endmodule
